// File: rtl/uart_pkg.sv
// Shared UART transmitter types and parameter defaults.
// Imported by uart_tx and by anything that instantiates it.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_PARITY_EN  = 0;
    localparam int DEF_PARITY_ODD = 0;
    localparam int DEF_STOP_BITS  = 1;
    localparam int IDX_W          = 3;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stops.
// Each level lasts one baud_tick period; the ARM state aligns to the tick grid.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int PARITY_EN  = DEF_PARITY_EN,
    parameter int PARITY_ODD = DEF_PARITY_ODD,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic                 system_clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_line,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 done_d;

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        line_d  = line_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // a tick in the accept cycle is deliberately ignored
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ (PARITY_ODD != 0);
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    line_d  = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (baud_tick) begin
                    line_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    line_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (idx_q != LAST_IDX) begin
                        line_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                    end else if (PARITY_EN != 0) begin
                        line_d  = par_q;
                        state_d = PARITY;
                    end else begin
                        line_d  = 1'b1;
                        stop_d  = 1'b0;
                        state_d = STOP;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    line_d  = 1'b1;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_q == LAST_STOP) begin
                        done_d  = 1'b1;
                        line_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);
    assign tx_line  = line_q;
    assign tx_done  = done_d;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations checked every cycle against
// a frame-level model, plus literal frame and timing expectations.
module tb_uart_tx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick  = 1'b0;
    logic [3:0] valid = '0;
    logic [7:0] data [4];
    logic [3:0] ready, line, busy, done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ch0 8N1, ch1 8E1, ch2 8O1, ch3 8N2
    int pen  [4] = '{0, 1, 1, 0};
    bit odd  [4] = '{0, 0, 1, 0};
    int nstp [4] = '{1, 1, 1, 2};

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx #(
            .DATA_BITS (8),
            .PARITY_EN ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD((g == 2) ? 1 : 0),
            .STOP_BITS ((g == 3) ? 2 : 1)
        ) u_dut (
            .system_clk(clk),
            .reset_n   (rst_n),
            .baud_tick (tick),
            .tx_data   (data[g]),
            .tx_valid  (valid[g]),
            .tx_ready  (ready[g]),
            .tx_line   (line[g]),
            .tx_busy   (busy[g]),
            .tx_done   (done[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame model: list of line levels; level k shown after tick k+1,
    // last level held one full tick, done pulses on the tick ending it.
    bit mbusy [4];
    int mpos  [4];
    int mn    [4];
    bit lv    [4][16];

    always @(posedge clk or negedge rst_n) begin
        for (int c = 0; c < 4; c++) begin
            if (!rst_n) begin
                mbusy[c] <= 1'b0;
            end else if (!mbusy[c]) begin
                if (valid[c]) begin
                    mbusy[c] <= 1'b1;
                    mpos[c]  <= 0;
                    mn[c]    <= 9 + pen[c] + nstp[c];
                    lv[c][0] <= 1'b0;
                    for (int i = 0; i < 8; i++) lv[c][1+i] <= data[c][i];
                    if (pen[c] != 0) lv[c][9] <= (^data[c]) ^ odd[c];
                    for (int s = 0; s < 2; s++)
                        if (s < nstp[c]) lv[c][9+pen[c]+s] <= 1'b1;
                end
            end else if (tick) begin
                if (mpos[c] == mn[c]) mbusy[c] <= 1'b0;
                else mpos[c] <= mpos[c] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            logic el;
            el = (mbusy[c] && mpos[c] > 0) ? lv[c][mpos[c]-1] : 1'b1;
            chk($sformatf("ch%0d line", c), line[c], el);
            chk($sformatf("ch%0d ready", c), ready[c], !mbusy[c]);
            chk($sformatf("ch%0d busy", c), busy[c], mbusy[c]);
            chk($sformatf("ch%0d done", c), done[c],
                mbusy[c] && tick && mpos[c] == mn[c]);
        end
    end

    task automatic send(int c, logic [7:0] d);
        int b;
        @(posedge clk);
        #2;
        data[c]  = d;
        valid[c] = 1'b1;
        b = 0;
        @(negedge clk);
        while (!ready[c] && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk($sformatf("ch%0d send ready", c), ready[c], 1);
        @(posedge clk);
        #2;
        valid[c] = 1'b0;
    endtask

    task automatic capture(int c, output logic [15:0] lvec, output int dk);
        int  k;
        bit  pend;
        lvec = '0;
        k    = 0;
        pend = 0;
        dk   = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pend) begin
                lvec[k-1] = line[c];
                pend = 0;
            end
            if (tick) begin
                k++;
                if (done[c]) begin
                    dk = k;
                    break;
                end
                pend = 1;
            end
        end
    endtask

    initial begin
        logic [15:0] lvec;
        int dk, b, dcyc, acyc;
        for (int c = 0; c < 4; c++) data[c] = '0;
        #3 rst_n = 1'b0;
        @(negedge clk);
        chk("reset ready", ready, 4'hF);
        chk("reset busy", busy, 4'h0);
        chk("reset line", line, 4'hF);
        chk("reset done", done, 4'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        send(0, 8'h55);
        capture(0, lvec, dk);
        chk("8N1 55 levels", lvec, 16'h02AA);
        chk("8N1 start->done ticks", dk - 1, 10);

        send(1, 8'h07);
        capture(1, lvec, dk);
        chk("8E1 07 levels", lvec, 16'h060E);
        chk("8E1 parity bit", lvec[9], 1);
        chk("8E1 start->done ticks", dk - 1, 11);

        send(2, 8'h00);
        capture(2, lvec, dk);
        chk("8O1 00 levels", lvec, 16'h0600);
        chk("8O1 parity bit", lvec[9], 1);
        chk("8O1 start->done ticks", dk - 1, 11);

        send(3, 8'hA3);
        capture(3, lvec, dk);
        chk("8N2 A3 levels", lvec, 16'h0746);
        chk("8N2 start->done ticks", dk - 1, 11);

        // back-to-back with tx_valid held; data changes while busy
        @(posedge clk);
        #2;
        data[0]  = 8'h12;
        valid[0] = 1'b1;
        b = 0;
        @(negedge clk);
        while (!ready[0] && b < 200) begin
            @(negedge clk);
            b++;
        end
        @(posedge clk);
        #2;
        data[0] = 8'h34;
        dcyc = -100;
        acyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done[0]) dcyc = cyc;
            if (ready[0]) begin
                acyc = cyc;
                break;
            end
        end
        chk("b2b accept after done", acyc - dcyc, 1);
        @(posedge clk);
        #2;
        valid[0] = 1'b0;
        capture(0, lvec, dk);
        chk("b2b 34 levels", lvec, 16'h0268);

        // accept coincident with a tick
        b = 0;
        @(negedge clk);
        while (!(tick && ready[0]) && b < 50) begin
            @(negedge clk);
            b++;
        end
        data[0]  = 8'h0F;
        valid[0] = 1'b1;
        @(posedge clk);
        #2;
        valid[0] = 1'b0;
        chk("coincident line idle", line[0], 1);
        chk("coincident accepted", busy[0], 1);
        capture(0, lvec, dk);
        chk("coincident 0F levels", lvec, 16'h021E);
        chk("coincident start->done ticks", dk - 1, 10);

        // reset in the middle of DATA
        send(0, 8'h5A);
        b = 0;
        for (int i = 0; i < 100 && b < 4; i++) begin
            @(negedge clk);
            if (tick) b++;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset line", line[0], 1);
        chk("midreset ready", ready[0], 1);
        chk("midreset busy", busy[0], 0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        send(0, 8'hC3);
        capture(0, lvec, dk);
        chk("post-reset C3 levels", lvec, 16'h0386);
        chk("post-reset start->done ticks", dk - 1, 10);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
